// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: initiator-side controller for the single-port data_memory.
// It accepts byte, halfword and word loads and stores from the datapath.
// Loads take one read cycle. The read data is lane-extracted and then sign- or zero-extended.
// Word stores take one write cycle.
// Sub-word stores are a read-modify-write: read the word, replace one lane, write it back.
// Misaligned requests skip memory entirely and return an error response.
// Optional feature: define DATA_MEM_ACCESS_COUNT_EN to add load_count/store_count outputs,
// which count successfully completed loads and stores.
module data_mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              mem_memread,
  output logic              mem_memwrite
`ifdef DATA_MEM_ACCESS_COUNT_EN
  ,
  output logic [CNT_W-1:0]  load_count,
  output logic [CNT_W-1:0]  store_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WRITE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Request fields latched at acceptance; the memory side is driven only from these.
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_merge;

  logic              w_misaligned;
  logic [ADDR_W-1:0] w_word_addr;
  logic [7:0]        w_rd_bytes [4];
  logic [3:0]        w_lane_hit;
  logic [7:0]        w_lane_src [4];
  logic [31:0]       w_merged;
  logic [7:0]        w_sel_byte;
  logic [15:0]       w_sel_half;
  logic [31:0]       w_load_ext;

  // A halfword must be 2-byte aligned. A word (size 10 or 11) must be 4-byte aligned.
  assign w_misaligned = ((req_size == 2'b01) & req_addr[0]) |
                        (req_size[1] & (req_addr[1:0] != 2'b00));

  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // Per-lane view of the read word and the lane-replace merge for sub-word stores.
  // A halfword store supplies wdata[7:0] to the even lane and wdata[15:8] to the odd lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_rd_bytes[gi] = mem_read_data[8*gi +: 8];
      assign w_lane_hit[gi] = r_size[0] ? (r_addr[1] == 1'(gi / 2))
                                        : (r_addr[1:0] == 2'(gi));
      assign w_lane_src[gi] = r_size[0] ? r_wdata[8*(gi % 2) +: 8] : r_wdata[7:0];
      assign w_merged[8*gi +: 8] = w_lane_hit[gi] ? w_lane_src[gi] : r_merge[8*gi +: 8];
    end
  endgenerate

  assign w_sel_byte = w_rd_bytes[r_addr[1:0]];
  assign w_sel_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];

  // Extend the addressed lane of the read word to 32 bits.
  always_comb begin
    w_load_ext = mem_read_data;
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & w_sel_byte[7]}}, w_sel_byte};
      2'b01:   w_load_ext = {{16{r_signed & w_sel_half[15]}}, w_sel_half};
      default: w_load_ext = mem_read_data;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misaligned)     w_state_next = S_RESP;
          else if (!req_we)     w_state_next = S_READ;
          else if (req_size[1]) w_state_next = S_WRITE;
          else                  w_state_next = S_RMW_RD;
        end
      end
      S_READ:   w_state_next = S_RESP;
      S_WRITE:  w_state_next = S_RESP;
      S_RMW_RD: w_state_next = S_RMW_WR;
      S_RMW_WR: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Moore outputs. The address and data buses are held at zero whenever no strobe is active.
  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = 32'h0;
    mem_address    = '0;
    mem_write_data = 32'h0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    case (r_state)
      S_IDLE: req_ready = ~reset;
      S_READ: begin
        mem_memread = 1'b1;
        mem_address = w_word_addr;
      end
      S_WRITE: begin
        mem_memwrite   = 1'b1;
        mem_address    = w_word_addr;
        mem_write_data = r_wdata;
      end
      S_RMW_RD: begin
        mem_memread = 1'b1;
        mem_address = w_word_addr;
      end
      S_RMW_WR: begin
        mem_memwrite   = 1'b1;
        mem_address    = w_word_addr;
        mem_write_data = w_merged;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = r_rdata;
      end
      default: ;
    endcase
  end

  // Latch the request on acceptance, capture load data, and capture the RMW read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_err    <= 1'b0;
      r_rdata  <= 32'h0;
      r_merge  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_err    <= w_misaligned;
            r_rdata  <= 32'h0;
          end
        end
        S_READ:   r_rdata <= w_load_ext;
        S_RMW_RD: r_merge <= mem_read_data;
        default: ;
      endcase
    end
  end

`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [CNT_W-1:0] r_load_count;
  logic [CNT_W-1:0] r_store_count;

  // Count completed accesses on the response cycle. Error responses are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_count  <= '0;
      r_store_count <= '0;
    end else if ((r_state == S_RESP) && !r_err) begin
      if (r_we) r_store_count <= r_store_count + 1'b1;
      else      r_load_count  <= r_load_count + 1'b1;
    end
  end

  assign load_count  = r_load_count;
  assign store_count = r_store_count;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit.
// A reference model builds the expected per-cycle outputs for each accepted request,
// working from the load/store rules over a shadow word array.
// A compare process checks every cycle against that model.
// Directed transactions also check hand-computed literal results.
module tb_data_mem_access_unit;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;
  logic              mem_memread;
  logic              mem_memwrite;
`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [CNT_W-1:0]  load_count;
  logic [CNT_W-1:0]  store_count;
`endif

  always #5 clk = ~clk;

  data_mem_access_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite)
`ifdef DATA_MEM_ACCESS_COUNT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  // Data memory: combinational read, write on the rising edge.
  logic [31:0] dmem [0:63];
  assign mem_read_data = dmem[mem_address[7:2]];
  always @(posedge clk) if (mem_memwrite) dmem[mem_address[7:2]] <= mem_write_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          resp;
    bit          err;
    logic [31:0] rdata;
    bit          commit;
    int          cidx;
    logic [31:0] cval;
    bit          is_ld;
    bit          is_st;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] ref_mem [0:63];
  int          m_ld = 0;
  int          m_st = 0;
  bit          model_on = 0;

  function automatic bit misaligned(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'b01) return a[0];
    if (sz[1]) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] w, logic [1:0] sz, logic [31:0] a, bit sgn);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] merge_val(logic [31:0] w, logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    if (sz == 2'b00) begin
      sh = 8 * int'(a[1:0]);
      mask = 32'h0000_00FF << sh;
    end else begin
      sh = 16 * int'(a[1]);
      mask = 32'h0000_FFFF << sh;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Retire one expected cycle per clock. On an acceptance, queue the request's whole timeline.
  always @(posedge clk) begin
    bit          was_empty;
    rec_t        r;
    logic [31:0] a;
    logic [31:0] w;
    was_empty = (exp_q.size() == 0);
    if (!was_empty) begin
      r = exp_q.pop_front();
      if (r.commit) ref_mem[r.cidx] = r.cval;
      if (!reset && r.is_ld) m_ld++;
      if (!reset && r.is_st) m_st++;
    end
    if (reset) begin
      exp_q.delete();
      m_ld = 0;
      m_st = 0;
    end else if (was_empty && req_valid) begin
      a = req_addr;
      w = ref_mem[a[7:2]];
      if (misaligned(req_size, a)) begin
        r = '{default: 0}; r.resp = 1; r.err = 1; exp_q.push_back(r);
      end else if (!req_we) begin
        r = '{default: 0}; r.rd = 1; r.addr = a & ~32'h3; exp_q.push_back(r);
        r = '{default: 0}; r.resp = 1; r.is_ld = 1;
        r.rdata = load_val(w, req_size, a, req_signed); exp_q.push_back(r);
      end else if (req_size[1]) begin
        r = '{default: 0}; r.wr = 1; r.addr = a & ~32'h3; r.wdata = req_wdata;
        r.commit = 1; r.cidx = int'(a[7:2]); r.cval = req_wdata; exp_q.push_back(r);
        r = '{default: 0}; r.resp = 1; r.is_st = 1; exp_q.push_back(r);
      end else begin
        r = '{default: 0}; r.rd = 1; r.addr = a & ~32'h3; exp_q.push_back(r);
        r = '{default: 0}; r.wr = 1; r.addr = a & ~32'h3;
        r.wdata = merge_val(w, req_size, a, req_wdata);
        r.commit = 1; r.cidx = int'(a[7:2]); r.cval = r.wdata; exp_q.push_back(r);
        r = '{default: 0}; r.resp = 1; r.is_st = 1; exp_q.push_back(r);
      end
    end
    model_on = 1;
  end

  // Compare every output on every cycle, at the falling edge.
  always @(negedge clk) begin
    rec_t e;
    bit   exp_ready;
    if (model_on) begin
      if (exp_q.size() > 0) e = exp_q[0];
      else e = '{default: 0};
      exp_ready = (exp_q.size() == 0) && !reset;
      chk("req_ready",      32'(req_ready),    32'(exp_ready));
      chk("mem_memread",    32'(mem_memread),  32'(e.rd));
      chk("mem_memwrite",   32'(mem_memwrite), 32'(e.wr));
      chk("mem_address",    mem_address,       e.addr);
      chk("mem_write_data", mem_write_data,    e.wdata);
      chk("resp_valid",     32'(resp_valid),   32'(e.resp));
      chk("resp_err",       32'(resp_err),     32'(e.err));
      chk("resp_rdata",     resp_rdata,        e.rdata);
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_req(input bit we, input logic [1:0] sz, input bit sgn,
                           input logic [31:0] a, input logic [31:0] wd, input bit immediate);
    if (!immediate) begin
      @(posedge clk);
      #2;
    end
    req_we = we; req_size = sz; req_signed = sgn; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL accept_timeout: addr %h not accepted within 20 cycles", a);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, output logic [31:0] rd, output bit err);
    rd = 32'hDEAD_BEEF;
    err = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd = resp_rdata;
        err = resp_err;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s_resp_timeout: no resp_valid within 10 cycles", name);
  endtask

  task automatic do_txn(input string name, input bit we, input logic [1:0] sz, input bit sgn,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    bit          err;
    start_req(we, sz, sgn, a, wd, 1'b0);
    wait_resp(name, rd, err);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    $display("txn %-8s we=%0b size=%0d signed=%0b addr=%h wdata=%h -> rdata=%h err=%0b",
             name, we, sz, sgn, a, wd, rd, err);
  endtask

  initial begin
    logic [31:0] rd;
    bit          err;
    for (int i = 0; i < 64; i++) begin
      dmem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    dmem[3] = 32'hABCD_1234;
    ref_mem[3] = 32'hABCD_1234;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Loads against word 0x0C = ABCD1234.
    do_txn("LW_0C",  1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hABCD_1234, 1'b0);
    do_txn("LB_0E",  1'b0, 2'b00, 1'b1, 32'h0E, 32'h0, 32'hFFFF_FFCD, 1'b0);
    do_txn("LBU_0E", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0, 32'h0000_00CD, 1'b0);
    do_txn("LH_0E",  1'b0, 2'b01, 1'b1, 32'h0E, 32'h0, 32'hFFFF_ABCD, 1'b0);
    do_txn("LHU_0C", 1'b0, 2'b01, 1'b0, 32'h0C, 32'h0, 32'h0000_1234, 1'b0);
    do_txn("LB_0C",  1'b0, 2'b00, 1'b1, 32'h0C, 32'h0, 32'h0000_0034, 1'b0);
    do_txn("LW11_0C", 1'b0, 2'b11, 1'b1, 32'h0C, 32'h0, 32'hABCD_1234, 1'b0);

    // Misaligned requests.
    do_txn("LW_0A",  1'b0, 2'b10, 1'b0, 32'h0A, 32'h0, 32'h0, 1'b1);
    do_txn("SH_0F",  1'b1, 2'b01, 1'b0, 32'h0F, 32'h1234, 32'h0, 1'b1);

    // Reset while the RMW read is in progress: abandon the store, leave memory untouched.
    start_req(1'b1, 2'b01, 1'b0, 32'h0C, 32'h5555, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 32'(req_ready), 32'h1);
    chk("rst_mid_resp",  32'(resp_valid), 32'h0);
    chk("rst_mid_strobe", 32'({mem_memread, mem_memwrite}), 32'h0);
    $display("txn RST_RMW reset during RMW_RD of SH 0x0C");
    do_txn("LW_0C_r", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hABCD_1234, 1'b0);

    // Sub-word stores.
    do_txn("SB_0D",  1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_00EE, 32'h0, 1'b0);
    do_txn("LW_0C_s", 1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hABCD_EE34, 1'b0);

    // Back-to-back: the load is presented while the store is still busy and must wait.
    start_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h1000_0001, 1'b0);
    $display("txn SW_10    accepted, LW_10 held behind it");
    start_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
    wait_resp("LW_10", rd, err);
    chk("LW_10_rdata", rd, 32'h1000_0001);
    chk("LW_10_err", 32'(err), 32'h0);
    $display("txn LW_10    -> rdata=%h err=%0b", rd, err);

    do_txn("SH_12",  1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_BEEF, 32'h0, 1'b0);
    do_txn("LW_10_h", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEF_0001, 1'b0);
    do_txn("LH_12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFF_BEEF, 1'b0);

    repeat (3) @(posedge clk);
`ifdef DATA_MEM_ACCESS_COUNT_EN
    @(negedge clk);
    chk("load_count",  load_count,  32'(m_ld));
    chk("store_count", store_count, 32'(m_st));
`endif
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Initiator-side controller for the single-port data_memory (address/write_data/read_data/memread/memwrite).
- Accepts load/store requests of byte, halfword or word size from the datapath and drives the memory strobes. Sub-word stores are done as read-modify-write sequences.
- Returns sign- or zero-extended load data and completion responses.
- Sits between the execute/memory pipeline stage and data_memory.

Parameters:
- ADDR_W, 32, request and memory address width.
- CNT_W, 32, width of the access counters (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- req_signed  input  1  sign-extend load result (ignored for stores/word)
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle completion pulse
- resp_err  output  1  misaligned request, qualified by resp_valid
- resp_rdata  output  32  extended load data; 0 for stores and errors
- mem_address  output  ADDR_W  word-aligned address to data_memory ({addr[ADDR_W-1:2],2'b00})
- mem_write_data  output  32  write data to data_memory
- mem_read_data  input  32  combinational read data from data_memory
- mem_memread  output  1  read strobe
- mem_memwrite  output  1  write strobe

Behaviour:
- Little-endian lanes: byte k = bits [8k+7:8k], selected by addr[1:0]; halfword selected by addr[1].
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP. Memory outputs are decoded from state plus latched request (Moore).
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/signed/addr/wdata.
  - Next state: RESP (misaligned, resp_err latched 1), READ (load), WRITE (word store) or RMW_RD (sub-word store).
- READ: mem_memread=1; mem_read_data lane-extracted, extended and registered at edge; -> RESP.
- WRITE: mem_memwrite=1, mem_write_data=wdata; -> RESP.
- RMW_RD: mem_memread=1; full word captured into merge register; -> RMW_WR.
- RMW_WR: mem_memwrite=1; mem_write_data=captured word with the addressed lane replaced by wdata[7:0]/[15:0]; -> RESP.
- RESP: resp_valid=1 for exactly one cycle. No response backpressure. -> IDLE.
- Latency (accept cycle = 0):
  - Misaligned: resp in cycle 1.
  - Load / word store: strobe in cycle 1, resp in cycle 2.
  - Sub-word store: memread cycle 1, memwrite cycle 2, resp cycle 3.
  - req_ready returns the cycle after RESP.
- Strobe rules: mem_memread and mem_memwrite are never high together. Both are 0 in IDLE, RESP and on misaligned requests.
- mem_address and mem_write_data are 0 whenever no strobe is active.
- Reset outputs: all 0 (req_ready=1 is asserted the cycle after reset deasserts, state IDLE); all latches cleared.
- Reset mid-operation: abandons the access at that edge; strobes deassert and no response is issued. A sub-word store interrupted in RMW_RD leaves memory unmodified.
- req_valid while req_ready=0 is ignored (not queued); the requester must hold it.
- Load extension: req_signed=1 replicates bit 7/15; otherwise zero-fill.

Optional Feature:
- Macro DATA_MEM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs load_count and store_count (CNT_W each), cleared by reset.
  - Each increments by 1 on the RESP cycle of a successful load/store; misaligned requests increment neither.
  - Counters wrap modulo 2^CNT_W.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Memory word at 0x0C = 0xABCD1234; LW 0x0C -> mem_memread=1 in cycle 1 only with mem_address=0x0C; resp_valid in cycle 2, resp_rdata=0xABCD1234, resp_err=0.
- LB signed 0x0E -> 0xFFFFFFCD; LBU 0x0E -> 0x000000CD; LH signed 0x0E -> 0xFFFFABCD; LHU 0x0C -> 0x00001234.
- SB 0x0D wdata 0x000000EE -> memread cycle 1, memwrite cycle 2 with mem_write_data=0xABCDEE34, resp cycle 3; following LW 0x0C returns 0xABCDEE34.
- LW 0x0A and SH 0x0F -> resp_err=1 in cycle 1, rdata 0, no strobe ever asserted, req_ready back in cycle 2.
- SH 0x0C wdata 0x5555 with reset high during RMW_RD -> next cycle all strobes 0, no resp_valid, req_ready=1; LW 0x0C still 0xABCD1234.
- Two back-to-back requests with req_valid held (SW 0x10 0x10000001 then LW 0x10) -> second accepted only when req_ready=1; LW returns 0x10000001. With DATA_MEM_ACCESS_COUNT_EN, load_count=1 and store_count=1.
